// File: rtl/wb_interconnect_tgt_port.sv
// wb_interconnect_tgt_port: target-side port stage of the Wishbone interconnect.
// It captures the request of the initiator granted by wb_interconnect_arb, drives
// one target with registered signals, routes ack/err/read data back to that
// initiator, and pulses arb_ack to release the arbiter.
// Optional feature macro: WB_INTERCONNECT_TGT_TIMEOUT_EN (ACTIVE-state watchdog).
module wb_interconnect_tgt_port #(
  parameter int unsigned N_INIT  = 2,
  parameter int unsigned ADR_W   = 32,
  parameter int unsigned DAT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_INIT-1:0]           gnt,
  output logic                        arb_ack,
  input  logic [N_INIT*ADR_W-1:0]     i_adr,
  input  logic [N_INIT*DAT_W-1:0]     i_dat_w,
  input  logic [N_INIT*(DAT_W/8)-1:0] i_sel,
  input  logic [N_INIT-1:0]           i_we,
  input  logic [N_INIT-1:0]           i_cyc,
  input  logic [N_INIT-1:0]           i_stb,
  output logic [DAT_W-1:0]            i_dat_r,
  output logic [N_INIT-1:0]           i_ack,
  output logic [N_INIT-1:0]           i_err,
  output logic [ADR_W-1:0]            t_adr,
  output logic [DAT_W-1:0]            t_dat_w,
  output logic [DAT_W/8-1:0]          t_sel,
  output logic                        t_we,
  output logic                        t_cyc,
  output logic                        t_stb,
  input  logic [DAT_W-1:0]            t_dat_r,
  input  logic                        t_ack,
  input  logic                        t_err
);

  localparam int unsigned SEL_W = DAT_W / 8;
  localparam int unsigned IDX_W = (N_INIT > 1) ? $clog2(N_INIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Reject illegal configurations at elaboration
  if ((DAT_W % 8) != 0 || N_INIT < 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("wb_interconnect_tgt_port: illegal parameter combination");
  end

  state_t              r_state;
  state_t              w_state_nxt;

  logic [IDX_W-1:0]    r_idx;
  logic [ADR_W-1:0]    r_t_adr;
  logic [DAT_W-1:0]    r_t_dat_w;
  logic [SEL_W-1:0]    r_t_sel;
  logic                r_t_we;
  logic                r_t_cyc;
  logic                r_t_stb;
  logic [DAT_W-1:0]    r_dat_r;
  logic [N_INIT-1:0]   r_i_ack;
  logic [N_INIT-1:0]   r_i_err;
  logic                r_arb_ack;

  logic [IDX_W-1:0]    w_idx_nxt;
  logic [ADR_W-1:0]    w_t_adr_nxt;
  logic [DAT_W-1:0]    w_t_dat_w_nxt;
  logic [SEL_W-1:0]    w_t_sel_nxt;
  logic                w_t_we_nxt;
  logic                w_t_cyc_nxt;
  logic                w_t_stb_nxt;
  logic [DAT_W-1:0]    w_dat_r_nxt;
  logic [N_INIT-1:0]   w_i_ack_nxt;
  logic [N_INIT-1:0]   w_i_err_nxt;
  logic                w_arb_ack_nxt;

  logic                w_gnt_hit;
  logic                w_cap_req;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [ADR_W-1:0]    w_cap_adr;
  logic [DAT_W-1:0]    w_cap_dat_w;
  logic [SEL_W-1:0]    w_cap_sel;
  logic                w_cap_we;
  logic                w_capture;
  logic                w_timeout;
  logic                w_term;
  logic                w_term_err;
  logic [N_INIT-1:0]   w_idx_onehot;

  // Lowest set grant bit selects the initiator whose request is a capture candidate
  always_comb begin
    w_gnt_hit   = 1'b0;
    w_cap_req   = 1'b0;
    w_gnt_idx   = '0;
    w_cap_adr   = '0;
    w_cap_dat_w = '0;
    w_cap_sel   = '0;
    w_cap_we    = 1'b0;
    for (int unsigned k = 0; k < N_INIT; k++) begin
      if (gnt[k] && !w_gnt_hit) begin
        w_gnt_hit   = 1'b1;
        w_cap_req   = i_cyc[k] & i_stb[k];
        w_gnt_idx   = IDX_W'(k);
        w_cap_adr   = i_adr[k*ADR_W +: ADR_W];
        w_cap_dat_w = i_dat_w[k*DAT_W +: DAT_W];
        w_cap_sel   = i_sel[k*SEL_W +: SEL_W];
        w_cap_we    = i_we[k];
      end
    end
  end

  assign w_capture    = (r_state == S_IDLE) && w_cap_req;
  assign w_term       = (r_state == S_ACTIVE) && (t_ack || t_err || w_timeout);
  assign w_term_err   = t_err || w_timeout;
  assign w_idx_onehot = N_INIT'(1) << r_idx;

`ifdef WB_INTERCONNECT_TGT_TIMEOUT_EN
  logic [15:0] r_wdog;

  // Watchdog restarts on capture and counts ACTIVE cycles with no target response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (w_capture) begin
      r_wdog <= '0;
    end else if ((r_state == S_ACTIVE) && !t_ack && !t_err) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  // Expire on the ACTIVE cycle whose increment would reach TIMEOUT
  assign w_timeout = (r_state == S_ACTIVE) && !t_ack && !t_err &&
                     (r_wdog == 16'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_cap_req) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_term)    w_state_nxt = S_RESP;
      S_RESP:                  w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered target request and responses
  always_comb begin
    w_idx_nxt     = r_idx;
    w_t_adr_nxt   = r_t_adr;
    w_t_dat_w_nxt = r_t_dat_w;
    w_t_sel_nxt   = r_t_sel;
    w_t_we_nxt    = r_t_we;
    w_t_cyc_nxt   = r_t_cyc;
    w_t_stb_nxt   = r_t_stb;
    w_dat_r_nxt   = r_dat_r;
    w_i_ack_nxt   = '0;
    w_i_err_nxt   = '0;
    w_arb_ack_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cap_req) begin
          w_idx_nxt     = w_gnt_idx;
          w_t_adr_nxt   = w_cap_adr;
          w_t_dat_w_nxt = w_cap_dat_w;
          w_t_sel_nxt   = w_cap_sel;
          w_t_we_nxt    = w_cap_we;
          w_t_cyc_nxt   = 1'b1;
          w_t_stb_nxt   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_term) begin
          w_t_cyc_nxt   = 1'b0;
          w_t_stb_nxt   = 1'b0;
          w_arb_ack_nxt = 1'b1;
          if (w_term_err) begin
            w_i_err_nxt = w_idx_onehot;
          end else begin
            w_i_ack_nxt = w_idx_onehot;
            w_dat_r_nxt = t_dat_r;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output registers; reset drops t_cyc/t_stb asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_t_adr   <= '0;
      r_t_dat_w <= '0;
      r_t_sel   <= '0;
      r_t_we    <= 1'b0;
      r_t_cyc   <= 1'b0;
      r_t_stb   <= 1'b0;
      r_dat_r   <= '0;
      r_i_ack   <= '0;
      r_i_err   <= '0;
      r_arb_ack <= 1'b0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_t_adr   <= w_t_adr_nxt;
      r_t_dat_w <= w_t_dat_w_nxt;
      r_t_sel   <= w_t_sel_nxt;
      r_t_we    <= w_t_we_nxt;
      r_t_cyc   <= w_t_cyc_nxt;
      r_t_stb   <= w_t_stb_nxt;
      r_dat_r   <= w_dat_r_nxt;
      r_i_ack   <= w_i_ack_nxt;
      r_i_err   <= w_i_err_nxt;
      r_arb_ack <= w_arb_ack_nxt;
    end
  end

  assign t_adr   = r_t_adr;
  assign t_dat_w = r_t_dat_w;
  assign t_sel   = r_t_sel;
  assign t_we    = r_t_we;
  assign t_cyc   = r_t_cyc;
  assign t_stb   = r_t_stb;
  assign i_dat_r = r_dat_r;
  assign i_ack   = r_i_ack;
  assign i_err   = r_i_err;
  assign arb_ack = r_arb_ack;

endmodule

// File: tb/tb_wb_interconnect_tgt_port.sv
// Self-checking bench for wb_interconnect_tgt_port (N_INIT=2, 32-bit bus).
`timescale 1ns/1ps
module tb_wb_interconnect_tgt_port;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   gnt;
  logic         arb_ack;
  logic [63:0]  i_adr;
  logic [63:0]  i_dat_w;
  logic [7:0]   i_sel;
  logic [1:0]   i_we, i_cyc, i_stb;
  logic [31:0]  i_dat_r;
  logic [1:0]   i_ack, i_err;
  logic [31:0]  t_adr, t_dat_w;
  logic [3:0]   t_sel;
  logic         t_we, t_cyc, t_stb;
  logic [31:0]  t_dat_r;
  logic         t_ack, t_err;

  always #5 clock = ~clock;

  wb_interconnect_tgt_port #(
    .N_INIT(2), .ADR_W(32), .DAT_W(32), .TIMEOUT(4)
  ) dut (
    .clock(clock), .reset(reset), .gnt(gnt), .arb_ack(arb_ack),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_dat_r(i_dat_r), .i_ack(i_ack),
    .i_err(i_err), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel),
    .t_we(t_we), .t_cyc(t_cyc), .t_stb(t_stb), .t_dat_r(t_dat_r),
    .t_ack(t_ack), .t_err(t_err)
  );

  typedef struct {
    logic [1:0]  gnt, cyc, stb, we;
    logic [31:0] adr0, adr1, dw0, dw1;
    logic [3:0]  sel0, sel1;
    int          waits;
    logic        ack, err;
    logic [31:0] rdata;
    int          exp_k;    // captured initiator, -1 when the grant is ignored
    logic        exp_err;
  } vec_t;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [31:0] exp_dat_r = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Spec-level choice: lowest granted initiator, accepted only if it has cyc&stb
  function automatic int model_pick(input logic [1:0] g, input logic [1:0] c, input logic [1:0] s);
    for (int i = 0; i < 2; i++)
      if (g[i]) return (c[i] && s[i]) ? i : -1;
    return -1;
  endfunction

  task automatic run_xfer(input vec_t v, input string tag);
    logic [70:0] exp_req;
    logic [1:0]  exp_vec;
    gnt = v.gnt; i_cyc = v.cyc; i_stb = v.stb; i_we = v.we;
    i_adr = {v.adr1, v.adr0}; i_dat_w = {v.dw1, v.dw0}; i_sel = {v.sel1, v.sel0};
    t_ack = 1'b0; t_err = 1'b0;
    if (v.exp_k < 0) begin
      tick();
      chk({tag, " ignored grant"}, {t_cyc, t_stb, i_ack, i_err, arb_ack}, '0);
      gnt = 2'b00; t_ack = v.ack; t_err = v.err; t_dat_r = v.rdata;
      tick();
      chk({tag, " stray term in idle"}, {t_cyc, i_ack, i_err, arb_ack}, '0);
      chk({tag, " dat_r kept"}, i_dat_r, exp_dat_r);
      t_ack = 1'b0; t_err = 1'b0;
    end else begin
      exp_vec = 2'b01 << v.exp_k;
      exp_req = (v.exp_k == 1) ? {v.adr1, v.dw1, v.sel1, v.we[1], 2'b11}
                               : {v.adr0, v.dw0, v.sel0, v.we[0], 2'b11};
      tick();
      chk({tag, " capture"}, {t_adr, t_dat_w, t_sel, t_we, t_cyc, t_stb}, exp_req);
      chk({tag, " no early pulse"}, {i_ack, i_err, arb_ack}, '0);
      for (int w = 0; w < v.waits; w++) begin
        i_adr = {$urandom, $urandom}; i_dat_w = {$urandom, $urandom};
        i_sel = 8'($urandom); i_we = 2'($urandom); i_cyc = 2'($urandom); i_stb = 2'($urandom);
        tick();
        chk({tag, " held"}, {t_adr, t_dat_w, t_sel, t_we, t_cyc, t_stb, i_ack, i_err, arb_ack},
            {exp_req, 5'b0});
      end
      t_ack = v.ack; t_err = v.err; t_dat_r = v.rdata;
      tick();
      if (v.exp_err) begin
        chk({tag, " err pulse"}, {i_err, i_ack}, {exp_vec, 2'b00});
      end else begin
        chk({tag, " ack pulse"}, {i_ack, i_err}, {exp_vec, 2'b00});
        exp_dat_r = v.rdata;
      end
      chk({tag, " arb_ack/cyc drop"}, {arb_ack, t_cyc, t_stb}, 3'b100);
      chk({tag, " dat_r"}, i_dat_r, exp_dat_r);
      gnt = 2'b00;
      tick();
      chk({tag, " resp end"}, {i_ack, i_err, arb_ack, t_cyc}, '0);
      t_ack = 1'b0; t_err = 1'b0; i_cyc = 2'b00; i_stb = 2'b00;
    end
  endtask

  initial begin
    vec_t vt[10];
    vec_t rv;
    logic [1:0] te;
    int cnt0, cnt1, cycles, turn, bad;

    vt[0] = '{2'b10, 2'b11, 2'b11, 2'b00, 32'h0, 32'h100, 32'h0, 32'h0, 4'hF, 4'hF,
              0, 1'b1, 1'b0, 32'hDEADBEEF, 1, 1'b0};
    vt[1] = '{2'b01, 2'b01, 2'b01, 2'b01, 32'h8, 32'h44, 32'h55AA, 32'h0, 4'hF, 4'h1,
              3, 1'b1, 1'b0, 32'h0BAD0BAD, 0, 1'b0};
    vt[2] = '{2'b01, 2'b11, 2'b11, 2'b00, 32'h40, 32'h80, 32'h0, 32'h0, 4'hF, 4'hF,
              1, 1'b1, 1'b1, 32'h12345678, 0, 1'b1};
    vt[3] = '{2'b11, 2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 32'h0, 32'h0, 4'hC, 4'h3,
              0, 1'b1, 1'b0, 32'h0000A5A5, 0, 1'b0};
    vt[4] = '{2'b10, 2'b01, 2'b11, 2'b00, 32'h1, 32'h2, 32'h0, 32'h0, 4'hF, 4'hF,
              0, 1'b1, 1'b0, 32'h77777777, -1, 1'b0};
    vt[5] = '{2'b00, 2'b11, 2'b11, 2'b00, 32'h1, 32'h2, 32'h0, 32'h0, 4'hF, 4'hF,
              0, 1'b0, 1'b1, 32'h66666666, -1, 1'b0};
    vt[6] = '{2'b10, 2'b11, 2'b01, 2'b10, 32'h1, 32'h2, 32'h0, 32'h0, 4'hF, 4'hF,
              0, 1'b1, 1'b0, 32'h55555555, -1, 1'b0};
    vt[7] = '{2'b10, 2'b10, 2'b10, 2'b00, 32'h0, 32'hF00, 32'h0, 32'h0, 4'h0, 4'hF,
              2, 1'b0, 1'b1, 32'h99999999, 1, 1'b1};
    vt[8] = '{2'b10, 2'b10, 2'b10, 2'b00, 32'h0, 32'hF04, 32'h0, 32'h0, 4'h0, 4'hF,
              1, 1'b1, 1'b0, 32'hCAFEF00D, 1, 1'b0};
    vt[9] = '{2'b10, 2'b11, 2'b11, 2'b10, 32'hAAA0, 32'hBBB0, 32'h1, 32'h11223344, 4'h3, 4'h6,
              0, 1'b1, 1'b0, 32'h0, 1, 1'b0};

    reset = 1'b1; gnt = '0; i_adr = '0; i_dat_w = '0; i_sel = '0; i_we = '0;
    i_cyc = '0; i_stb = '0; t_dat_r = '0; t_ack = 1'b0; t_err = 1'b0;
    tick(); tick();
    chk("reset outputs", {t_adr, t_dat_w, t_sel, t_we, t_cyc, t_stb, i_ack, i_err, arb_ack, i_dat_r}, '0);
    reset = 1'b0;
    tick();
    chk("post-reset idle", {t_cyc, t_stb, i_ack, i_err, arb_ack}, '0);

    for (int i = 0; i < 10; i++) run_xfer(vt[i], $sformatf("vec%0d", i));

    // Reset two cycles into ACTIVE: request drops before the next edge, no pulse
    gnt = 2'b01; i_cyc = 2'b01; i_stb = 2'b01; i_adr = {32'h0, 32'h123}; i_we = 2'b00;
    tick(); tick();
    chk("pre-reset active", {t_cyc, t_stb, t_adr}, {2'b11, 32'h123});
    reset = 1'b1;
    #1;
    chk("async reset drop", {t_adr, t_dat_w, t_sel, t_we, t_cyc, t_stb, i_ack, i_err, arb_ack, i_dat_r}, '0);
    exp_dat_r = '0;
    t_ack = 1'b1;
    tick();
    chk("no pulse in reset", {i_ack, i_err, arb_ack, t_cyc}, '0);
    reset = 1'b0; t_ack = 1'b0; gnt = 2'b00; i_cyc = 2'b00; i_stb = 2'b00;
    tick();
    chk("after reset release", {i_ack, i_err, arb_ack, t_cyc}, '0);
    run_xfer(vt[0], "restart");

    // Randomized transfers checked against the transaction-level model
    for (int n = 0; n < 40; n++) begin
      rv.gnt  = 2'($urandom);
      rv.cyc  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      rv.stb  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      rv.we   = 2'($urandom);
      rv.adr0 = $urandom; rv.adr1 = $urandom; rv.dw0 = $urandom; rv.dw1 = $urandom;
      rv.sel0 = 4'($urandom); rv.sel1 = 4'($urandom);
      rv.waits = $urandom_range(0, 5);
      te = 2'($urandom_range(1, 3));
      rv.ack = te[0]; rv.err = te[1];
      rv.rdata = $urandom;
      rv.exp_k = model_pick(rv.gnt, rv.cyc, rv.stb);
      rv.exp_err = rv.err;
      run_xfer(rv, $sformatf("rand%0d", n));
    end

    // Round-robin arbiter stand-in: both initiators request, grant rotates on arb_ack
    cnt0 = 0; cnt1 = 0; cycles = 0; turn = 0;
    i_cyc = 2'b11; i_stb = 2'b11; i_we = 2'b00; i_adr = {32'h2000_0010, 32'h1000_0000};
    for (int x = 0; x < 8; x++) begin
      gnt = 2'b01 << turn;
      tick(); cycles++;
      chk("arb t_adr", t_adr, (x % 2 == 1) ? 32'h2000_0010 : 32'h1000_0000);
      t_ack = 1'b1; t_dat_r = 32'(x) + 32'h100;
      tick(); cycles++;
      t_ack = 1'b0;
      if (i_ack == 2'b01) cnt0++;
      if (i_ack == 2'b10) cnt1++;
      chk("arb order", {i_ack, arb_ack}, {2'b01 << (x % 2), 1'b1});
      exp_dat_r = 32'(x) + 32'h100;
      chk("arb dat_r", i_dat_r, exp_dat_r);
      if (arb_ack) turn = 1 - turn;
      tick(); cycles++;
    end
    chk("arb counts", {32'(cnt0), 32'(cnt1), 32'(cycles)}, {32'd4, 32'd4, 32'd24});
    gnt = 2'b00; i_cyc = 2'b00; i_stb = 2'b00;
    tick();

    // Silent target
    gnt = 2'b10; i_cyc = 2'b10; i_stb = 2'b10; i_adr = {32'h0000_0ABC, 32'h0};
    tick();
    chk("silent capture", {t_cyc, t_adr}, {1'b1, 32'h0000_0ABC});
`ifdef WB_INTERCONNECT_TGT_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("wdog waiting", {t_cyc, i_err, i_ack, arb_ack}, {1'b1, 5'b0});
    end
    tick();
    chk("wdog expire", {i_err, i_ack, arb_ack, t_cyc, t_stb}, {2'b10, 2'b00, 1'b1, 2'b00});
    gnt = 2'b00; t_ack = 1'b1;
    tick();
    chk("late ack resp", {i_ack, i_err, arb_ack}, '0);
    tick();
    chk("late ack idle", {i_ack, i_err, arb_ack, t_cyc}, '0);
    t_ack = 1'b0;
`else
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (!t_cyc || i_ack != 2'b00 || i_err != 2'b00 || arb_ack) bad++;
    end
    chk("no watchdog hold", 32'(bad), 32'd0);
    t_ack = 1'b1; t_dat_r = 32'h0F0F0F0F;
    tick();
    chk("silent finally acked", {i_ack, arb_ack, t_cyc}, {2'b10, 1'b1, 1'b0});
    t_ack = 1'b0; gnt = 2'b00;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
